vec_pair_loader: RTL and testbench

VEC_PAIR_LOADER -- requirements
Module: vec_pair_loader

---
 rtl/dp_pkg.sv | 14 +
 rtl/vec_pair_loader_if.sv | 30 +++
 rtl/vpl_fifo2.sv | 58 +++++
 rtl/vec_pair_loader.sv | 136 +++++++++++++
 tb/tb_vec_pair_loader.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the vector-pair loader and the dot_product stage:
// data/length widths and the loader state encoding.
package dp_pkg;

    localparam int DP_WIDTH = 16;
    localparam int DP_LEN_W = 6;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_LOAD  = 2'd1,
        LD_DRAIN = 2'd2
    } loader_state_e;

endpackage

// File: rtl/vec_pair_loader_if.sv
// Host-side tagged element stream plus the A and B streams toward dot_product.
interface vec_pair_loader_if
    import dp_pkg::*;
#(
    parameter int WIDTH = DP_WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;

    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;

    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid
    );

endinterface

// File: rtl/vpl_fifo2.sv
// Two-entry FIFO with a registered head; push into a full FIFO is legal when
// the head is popped in the same cycle. Storage clears on reset.
module vpl_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem0;
    logic [WIDTH-1:0] mem1;
    logic [1:0]       cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == 2'd0);
    assign full    = (cnt == 2'd2);
    assign rdata   = mem0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem0 <= '0;
            mem1 <= '0;
            cnt  <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) mem0 <= wdata;
                    else             mem1 <= wdata;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    mem0 <= mem1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; the new word lands behind the survivor
                    if (cnt == 2'd1) begin
                        mem0 <= wdata;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= wdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/vec_pair_loader.sv
// Splits a tagged host stream into the A and B operand vectors of a dot
// product, buffering each channel in a 2-entry FIFO.
//
// state    | meaning
// ---------+------------------------------------------------------------
// LD_IDLE  | waiting for start; in_ready low, FIFOs empty
// LD_LOAD  | accepting beats until both channels hold len elements
// LD_DRAIN | all elements counted; waiting for both FIFOs to empty
module vec_pair_loader
    import dp_pkg::*;
#(
    parameter int WIDTH = DP_WIDTH,
    parameter int LEN_W = DP_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err_extra,
    vec_pair_loader_if.slave bus
);

    loader_state_e state;
    loader_state_e state_nxt;

    logic [LEN_W:0] len_q;
    logic [LEN_W:0] cnt_a;
    logic [LEN_W:0] cnt_b;
    logic [LEN_W:0] cnt_a_nxt;
    logic [LEN_W:0] cnt_b_nxt;
    logic [LEN_W:0] sel_cnt;

    logic sel_done;
    logic sel_room;
    logic in_ready;
    logic beat;
    logic drop;
    logic start_ok;

    logic a_push, a_pop, a_full, a_empty;
    logic b_push, b_pop, b_full, b_empty;

    assign a_pop = !a_empty && bus.a_ready;
    assign b_pop = !b_empty && bus.b_ready;

    // A beat for a channel that already has len elements is accepted and dropped
    always_comb begin
        sel_cnt   = bus.in_sel ? cnt_b : cnt_a;
        sel_done  = (sel_cnt == len_q);
        sel_room  = bus.in_sel ? (!b_full || b_pop) : (!a_full || a_pop);
        in_ready  = (state == LD_LOAD) && (sel_done || sel_room);
        beat      = bus.in_valid && in_ready;
        a_push    = beat && !bus.in_sel && !sel_done;
        b_push    = beat &&  bus.in_sel && !sel_done;
        drop      = beat && sel_done;
        cnt_a_nxt = cnt_a + (LEN_W+1)'(a_push);
        cnt_b_nxt = cnt_b + (LEN_W+1)'(b_push);
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        start_ok  = 1'b0;
        unique case (state)
            LD_IDLE: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = (len == '0) ? LD_DRAIN : LD_LOAD;
                end
            end
            LD_LOAD: begin
                if ((cnt_a_nxt == len_q) && (cnt_b_nxt == len_q))
                    state_nxt = LD_DRAIN;
            end
            LD_DRAIN: begin
                if (a_empty && b_empty) begin
                    done      = 1'b1;
                    state_nxt = LD_IDLE;
                end
            end
            default: state_nxt = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LD_IDLE;
            len_q     <= '0;
            cnt_a     <= '0;
            cnt_b     <= '0;
            err_extra <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                len_q     <= {1'b0, len};
                cnt_a     <= '0;
                cnt_b     <= '0;
                err_extra <= 1'b0;
            end else begin
                cnt_a <= cnt_a_nxt;
                cnt_b <= cnt_b_nxt;
                if (drop) err_extra <= 1'b1;
            end
        end
    end

    vpl_fifo2 #(.WIDTH(WIDTH)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .push  (a_push),
        .pop   (a_pop),
        .wdata (bus.in_data),
        .rdata (bus.a_data),
        .empty (a_empty),
        .full  (a_full)
    );

    vpl_fifo2 #(.WIDTH(WIDTH)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .push  (b_push),
        .pop   (b_pop),
        .wdata (bus.in_data),
        .rdata (bus.b_data),
        .empty (b_empty),
        .full  (b_full)
    );

    assign busy         = (state != LD_IDLE);
    assign bus.in_ready = in_ready;
    assign bus.a_valid  = !a_empty;
    assign bus.b_valid  = !b_empty;

endmodule

// File: tb/tb_vec_pair_loader.sv
// Randomised bench for vec_pair_loader against a queue-based model of the
// expected A/B vectors, drop flag and done timing.
module tb_vec_pair_loader;
    import dp_pkg::*;

    localparam int W  = DP_WIDTH;
    localparam int LW = DP_LEN_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          err_extra;

    vec_pair_loader_if #(.WIDTH(W)) bus ();

    vec_pair_loader #(.WIDTH(W), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err_extra (err_extra),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc;
    int last_edge;
    int done_cnt;
    bit any_valid;
    bit stall_seen;
    bit rdy_rand;
    int b_hold;

    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];
    bit           q_sel[$];
    logic [W-1:0] q_data[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle_counter();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #1;
            bus.a_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (b_hold > 0) begin
                bus.b_ready = 1'b0;
                b_hold--;
            end else begin
                bus.b_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    endtask

    // pops happen at the next rising edge; done must appear in the cycle after the last one
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.a_valid || bus.b_valid) any_valid = 1'b1;
                if (bus.in_valid && bus.in_sel && !bus.in_ready && !bus.b_ready) stall_seen = 1'b1;
                if (bus.a_valid && bus.a_ready) begin
                    chk("a_pop_expected", 32'(exp_a.size() > 0), 1);
                    if (exp_a.size() > 0) chk("a_data", bus.a_data, exp_a.pop_front());
                    last_edge = cyc + 1;
                end
                if (bus.b_valid && bus.b_ready) begin
                    chk("b_pop_expected", 32'(exp_b.size() > 0), 1);
                    if (exp_b.size() > 0) chk("b_data", bus.b_data, exp_b.pop_front());
                    last_edge = cyc + 1;
                end
                if (done) begin
                    done_cnt++;
                    chk("done_time", cyc, last_edge);
                end
            end
        end
    endtask

    task automatic add_beat(input bit s, input logic [W-1:0] d);
        q_sel.push_back(s);
        q_data.push_back(d);
    endtask

    // first l beats of each channel are kept in order; the rest are drops
    task automatic build_model(input int l, output bit e);
        int ca;
        int cb;
        ca = 0;
        cb = 0;
        e  = 1'b0;
        exp_a.delete();
        exp_b.delete();
        foreach (q_sel[i]) begin
            if (q_sel[i]) begin
                if (cb < l) begin exp_b.push_back(q_data[i]); cb++; end
                else e = 1'b1;
            end else begin
                if (ca < l) begin exp_a.push_back(q_data[i]); ca++; end
                else e = 1'b1;
            end
        end
    endtask

    task automatic send_beats(input int bogus_at, input int bogus_len);
        int k;
        for (int i = 0; i < q_sel.size(); i++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = q_sel[i];
            bus.in_data  = q_data[i];
            if (i == bogus_at) begin
                start = 1'b1;
                len   = LW'(bogus_len);
            end
            for (k = 0; k < 200; k++) begin
                @(negedge clk);
                if (bus.in_ready) break;
            end
            if (k >= 200) chk("beat_timeout", k, 0);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_load(input string name, input int l, input int bogus_at, input int bogus_len);
        bit e;
        build_model(l, e);
        done_cnt   = 0;
        any_valid  = 1'b0;
        stall_seen = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        len   = LW'(l);
        @(posedge clk);
        #1;
        start     = 1'b0;
        last_edge = cyc;
        chk({name, "_busy_after_start"}, busy, 1);
        send_beats(bogus_at, bogus_len);
        for (int k = 0; k < 400; k++) begin
            if (done_cnt > 0) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk({name, "_done_count"}, done_cnt, 1);
        chk({name, "_a_left"}, exp_a.size(), 0);
        chk({name, "_b_left"}, exp_b.size(), 0);
        chk({name, "_err_extra"}, err_extra, 32'(e));
        chk({name, "_busy_end"}, busy, 0);
    endtask

    initial begin
        bit e;
        int l;
        int na;
        int nb;
        rst          = 1'b1;
        start        = 1'b0;
        len          = '0;
        bus.in_valid = 1'b0;
        bus.in_sel   = 1'b0;
        bus.in_data  = '0;
        bus.a_ready  = 1'b1;
        bus.b_ready  = 1'b1;
        rdy_rand     = 1'b0;
        b_hold       = 0;
        cyc          = 0;
        last_edge    = 0;
        done_cnt     = 0;
        fork
            cycle_counter();
            ready_drv();
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_a_valid", bus.a_valid, 0);
        chk("rst_b_valid", bus.b_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_extra, 0);
        chk("rst_a_data", bus.a_data, 0);
        chk("rst_b_data", bus.b_data, 0);

        // all A then all B, downstream always ready
        q_sel.delete(); q_data.delete();
        for (int i = 0; i < 16; i++) add_beat(1'b0, W'(2 * i));
        for (int i = 0; i < 16; i++) add_beat(1'b1, W'(2 * i + 1));
        run_load("seq16", 16, -1, 0);

        // alternating with B backpressure for 10 cycles
        q_sel.delete(); q_data.delete();
        for (int i = 0; i < 4; i++) begin
            add_beat(1'b0, W'($urandom));
            add_beat(1'b1, W'($urandom));
        end
        b_hold = 10;
        run_load("bstall", 4, -1, 0);
        chk("bstall_in_ready_dropped", stall_seen, 1);

        // extra A beat is dropped and flagged
        q_sel.delete(); q_data.delete();
        add_beat(1'b0, W'(7)); add_beat(1'b0, W'(8)); add_beat(1'b0, W'(9));
        add_beat(1'b1, W'(21)); add_beat(1'b1, W'(22));
        run_load("extra", 2, -1, 0);

        // zero-length load
        q_sel.delete(); q_data.delete();
        run_load("len0", 0, -1, 0);
        chk("len0_no_valid", any_valid, 0);

        // reset in the middle of a 16-element load
        q_sel.delete(); q_data.delete();
        for (int i = 0; i < 5; i++) add_beat(1'b0, W'($urandom));
        build_model(16, e);
        @(posedge clk);
        #1;
        start = 1'b1;
        len   = LW'(16);
        @(posedge clk);
        #1;
        start = 1'b0;
        send_beats(-1, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_a.delete();
        exp_b.delete();
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_a_valid", bus.a_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_a_data", bus.a_data, 0);
        q_sel.delete(); q_data.delete();
        add_beat(1'b0, W'($urandom)); add_beat(1'b1, W'($urandom));
        add_beat(1'b1, W'($urandom)); add_beat(1'b0, W'($urandom));
        add_beat(1'b0, W'($urandom)); add_beat(1'b1, W'($urandom));
        run_load("after_rst", 3, -1, 0);

        // start during LOAD with a shorter len must be ignored
        q_sel.delete(); q_data.delete();
        for (int i = 0; i < 6; i++) begin
            add_beat(1'b1, W'($urandom));
            add_beat(1'b0, W'($urandom));
        end
        run_load("ign_start", 6, 2, 2);

        // random interleave, random downstream readiness, occasional drop
        rdy_rand = 1'b1;
        for (int t = 0; t < 8; t++) begin
            l = (t == 7) ? 63 : int'($urandom_range(1, 12));
            q_sel.delete(); q_data.delete();
            na = l;
            nb = (t % 3 == 1) ? l - 1 : l;
            while (na + nb > 0) begin
                if (na > 0 && (nb == 0 || $urandom_range(0, 1) == 0)) begin
                    add_beat(1'b0, W'($urandom)); na--;
                end else begin
                    add_beat(1'b1, W'($urandom)); nb--;
                end
            end
            if (t % 3 == 1) begin
                add_beat(1'b0, W'($urandom));
                add_beat(1'b1, W'($urandom));
            end
            run_load($sformatf("rnd%0d", t), l, -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
